// File: rtl/logic_unit_sweep.sv
// logic_unit_sweep: registered bitwise logic unit with an exhaustive (a, b) truth-table sweep engine.
module logic_unit_sweep #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             sweep_start,
    input  logic [2:0]       sweep_op,
    input  logic             sweep_pause,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [2:0]       out_op,
    output logic [WIDTH-1:0] out_y,
    output logic             busy,
    output logic             done
);
    localparam int CW = 2 * WIDTH;
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t           state, next_state;
    logic [CW-1:0]    cnt, cnt_inc, nxt_cnt;
    logic [2:0]       op_q, ld_op;
    logic [WIDTH-1:0] ld_a, ld_b;
    logic             sweeping, ld, ld_done;

    function automatic logic [WIDTH-1:0] f(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    f = ~a;
            3'd1:    f = a & b;
            3'd2:    f = a | b;
            3'd3:    f = a ^ b;
            3'd4:    f = ~(a & b);
            3'd5:    f = ~(a | b);
            3'd6:    f = ~(a ^ b);
            default: f = a;
        endcase
    endfunction

    assign cnt_inc  = cnt + CW'(1);
    assign sweeping = state == SWEEP;
    assign busy     = sweeping;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next_state;

    always_comb begin
        next_state = state;
        if (!sweeping && sweep_start) next_state = SWEEP;
        else if (sweeping && !sweep_pause && &cnt) next_state = IDLE;
    end

    // cnt indexes the vector currently on the outputs; the next one is built from cnt+1
    always_comb begin
        ld      = sweeping ? (!sweep_pause && !(&cnt)) : (sweep_start || in_valid);
        ld_a    = sweeping ? cnt_inc[CW-1:WIDTH] : sweep_start ? {WIDTH{1'b0}} : in_a;
        ld_b    = sweeping ? cnt_inc[WIDTH-1:0] : sweep_start ? {WIDTH{1'b0}} : in_b;
        ld_op   = sweeping ? op_q : sweep_start ? sweep_op : in_op;
        ld_done = sweeping && ld && &cnt_inc;
        nxt_cnt = !sweeping ? {CW{1'b0}} : sweep_pause ? cnt : ld ? cnt_inc : {CW{1'b0}};
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt       <= '0;
            op_q      <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_op    <= '0;
            out_y     <= '0;
        end else begin
            cnt       <= nxt_cnt;
            out_valid <= ld;
            done      <= ld_done;
            if (!sweeping && sweep_start) op_q <= sweep_op;
            if (ld) begin
                out_a  <= ld_a;
                out_b  <= ld_b;
                out_op <= ld_op;
                out_y  <= f(ld_op, ld_a, ld_b);
            end
        end
endmodule
